// File: rtl/yield_pkg.sv
// Shared types and defaults for the yield collector.
// Provides the FSM state enum, default sizes and count width helper.
package yield_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } yc_state_t;

    localparam int WIDTH_DEF = 32;
    localparam int NOUT_DEF  = 2;
    localparam int DEPTH_DEF = 8;

    // Width needed to hold an occupancy of 0..depth.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/yield_collector_if.sv
// Bundle of the producer-side and sink-side signals of yield_collector.
// master: producer/sink driver; slave: the collector itself.
interface yield_collector_if
    import yield_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NOUT  = NOUT_DEF,
    parameter int DEPTH = DEPTH_DEF
);

    logic                      start;
    logic                      in_valid;
    logic [NOUT*WIDTH-1:0]     in_data;
    logic                      in_done;
    logic                      out_valid;
    logic                      out_ready;
    logic [NOUT*WIDTH-1:0]     out_data;
    logic                      out_last;
    logic [count_w(DEPTH)-1:0] count;
    logic                      overflow;
    logic                      done;

    modport master (
        output start, in_valid, in_data, in_done, out_ready,
        input  out_valid, out_data, out_last, count, overflow, done
    );

    modport slave (
        input  start, in_valid, in_data, in_done, out_ready,
        output out_valid, out_data, out_last, count, overflow, done
    );

endinterface

// File: rtl/yield_fifo_mem.sv
// Tuple FIFO storage: sync write, async (fall-through) read, count-based flags.
// Ports: clk, rst_n, clear, push, pop, wdata, rdata, count, full, empty.
module yield_fifo_mem
    import yield_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NOUT  = NOUT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [NOUT*WIDTH-1:0]     wdata,
    output logic [NOUT*WIDTH-1:0]     rdata,
    output logic [count_w(DEPTH)-1:0] count,
    output logic                      full,
    output logic                      empty
);

    localparam int DW = NOUT * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    localparam logic [AW-1:0] P_ONE = AW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Flags come from the occupancy, so a full FIFO with equal
    // pointers is never mistaken for an empty one.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + P_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + P_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + C_ONE;
                2'b01:   count <= count - C_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/yield_collector.sv
// Captures generator output tuples into a FIFO and replays them on a
// ready/valid stream; flags overflow and run completion.
// Ports: _clock, _reset_n, _start, _in_valid/_in_data/_in_done (producer),
// _out_valid/_out_ready/_out_data/_out_last (sink), _count, _overflow, _done.
module yield_collector
    import yield_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NOUT  = NOUT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      _clock,
    input  logic                      _reset_n,
    input  logic                      _start,
    input  logic                      _in_valid,
    input  logic [NOUT*WIDTH-1:0]     _in_data,
    input  logic                      _in_done,
    output logic                      _out_valid,
    input  logic                      _out_ready,
    output logic [NOUT*WIDTH-1:0]     _out_data,
    output logic                      _out_last,
    output logic [count_w(DEPTH)-1:0] _count,
    output logic                      _overflow,
    output logic                      _done
);

    localparam int DW = NOUT * WIDTH;
    localparam int CW = count_w(DEPTH);

    yc_state_t     state;
    yc_state_t     state_nx;
    logic          done_seen;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full;
    logic          empty;
    logic [DW-1:0] rdata;

    yield_fifo_mem #(
        .WIDTH (WIDTH),
        .NOUT  (NOUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (_clock),
        .rst_n (_reset_n),
        .clear (_start),
        .push  (push),
        .pop   (pop),
        .wdata (_in_data),
        .rdata (rdata),
        .count (_count),
        .full  (full),
        .empty (empty)
    );

    // A flush discards any handshake in the same cycle.
    assign _out_valid = !empty;
    assign pop  = _out_valid && _out_ready && !_start;
    // A concurrent pop frees a slot, so a full FIFO still accepts.
    assign push = (state == COLLECT) && _in_valid && !_start
                  && (!full || pop);
    assign drop = (state == COLLECT) && _in_valid && !_start
                  && full && !pop;

    // Storage is not reset, so mask data while nothing is presented.
    assign _out_data = _out_valid ? rdata : '0;
    assign _out_last = _out_valid && (_count == CW'(1))
                       && (state == DRAIN);
    assign _done     = (state == DONE);

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                state_nx = IDLE;
            end
            COLLECT: begin
                if (_in_done || done_seen) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (empty) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (_start) begin
            state_nx = COLLECT;
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            done_seen <= 1'b0;
        end else if (_start) begin
            done_seen <= 1'b0;
        end else if (state == COLLECT && _in_done) begin
            done_seen <= 1'b1;
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            _overflow <= 1'b0;
        end else if (_start) begin
            _overflow <= 1'b0;
        end else if (drop) begin
            _overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_yield_collector.sv
// Self-checking bench for yield_collector: queue model checked every cycle
// plus directed scenarios with literal expectations.
module tb_yield_collector;
    import yield_pkg::*;

    typedef logic [63:0] tup_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    yield_collector_if bus ();

    yield_collector dut (
        ._clock     (clk),
        ._reset_n   (rst_n),
        ._start     (bus.start),
        ._in_valid  (bus.in_valid),
        ._in_data   (bus.in_data),
        ._in_done   (bus.in_done),
        ._out_valid (bus.out_valid),
        ._out_ready (bus.out_ready),
        ._out_data  (bus.out_data),
        ._out_last  (bus.out_last),
        ._count     (bus.count),
        ._overflow  (bus.overflow),
        ._done      (bus.done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tup_t tup(input int a, input int b);
        return {32'(b), 32'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: a queue of tuples plus run-phase flags.
    tup_t mq[$];
    bit   m_ovf;
    bit   m_coll;
    bit   m_drain;
    bit   m_fin;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_ovf = 0; m_coll = 0; m_drain = 0; m_fin = 0;
            end else if (bus.start) begin
                mq.delete();
                m_ovf = 0; m_coll = 1; m_drain = 0; m_fin = 0;
            end else begin
                bit p;
                bit w;
                int n;
                n = mq.size();
                p = (n > 0) && bus.out_ready;
                w = m_coll && bus.in_valid && (n < 8 || p);
                if (m_coll && bus.in_valid && n == 8 && !p) m_ovf = 1;
                if (m_drain && n == 0) begin
                    m_drain = 0;
                    m_fin = 1;
                end
                if (m_coll && bus.in_done) begin
                    m_coll = 0;
                    m_drain = 1;
                end
                if (p) void'(mq.pop_front());
                if (w) mq.push_back(bus.in_data);
            end
        end
    end

    // Every-cycle compare against the model, plus a log of what the
    // DUT actually handed to the sink.
    tup_t log_q[$];

    initial begin
        forever begin
            @(negedge clk);
            begin
                bit ev;
                ev = mq.size() > 0;
                chk("m_valid", 64'(bus.out_valid), 64'(ev));
                chk("m_count", 64'(bus.count), 64'(mq.size()));
                chk("m_ovf", 64'(bus.overflow), 64'(m_ovf));
                chk("m_done", 64'(bus.done), 64'(m_fin));
                chk("m_last", 64'(bus.out_last),
                    64'(ev && mq.size() == 1 && m_drain));
                if (ev) chk("m_data", bus.out_data, mq[0]);
                if (rst_n && bus.out_valid && bus.out_ready && !bus.start)
                    log_q.push_back(bus.out_data);
            end
        end
    end

    task automatic cyc(input logic st, input logic iv, input tup_t d,
                       input logic dn, input logic rdy);
        bus.start     = st;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_done   = dn;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_until_done(input int bound);
        int k = 0;
        while (!bus.done && k < bound) begin
            cyc(0, 0, '0, 0, 1);
            k++;
        end
        chk("drain_timeout", 64'(bus.done), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 0; bus.in_valid = 0; bus.in_data = '0;
        bus.in_done = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_count", 64'(bus.count), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_data", bus.out_data, 64'(0));
        rst_n = 1'b1;
        cyc(0, 1, tup(7, 7), 0, 1);
        chk("idle_ignore", 64'(bus.count), 64'(0));

        // Basic run
        cyc(1, 0, '0, 0, 1);
        cyc(0, 1, tup(1, 2), 0, 1);
        chk("basic_h0", bus.out_data, tup(1, 2));
        chk("basic_l0", 64'(bus.out_last), 64'(0));
        cyc(0, 1, tup(3, 4), 1, 1);
        chk("basic_h1", bus.out_data, tup(3, 4));
        chk("basic_l1", 64'(bus.out_last), 64'(1));
        cyc(0, 0, '0, 0, 1);
        chk("basic_empty", 64'(bus.out_valid), 64'(0));
        chk("basic_nd", 64'(bus.done), 64'(0));
        cyc(0, 0, '0, 0, 1);
        chk("basic_done", 64'(bus.done), 64'(1));

        // Backpressure / overflow
        cyc(1, 0, '0, 0, 0);
        for (int k = 0; k < 9; k++) cyc(0, 1, tup(k, -k), 0, 0);
        chk("ovf_count", 64'(bus.count), 64'(8));
        chk("ovf_flag", 64'(bus.overflow), 64'(1));
        log_q.delete();
        cyc(0, 0, '0, 1, 1);
        drain_until_done(20);
        chk("ovf_len", 64'(log_q.size()), 64'(8));
        for (int k = 0; k < 8 && k < log_q.size(); k++)
            chk("ovf_order", log_q[k], tup(k, -k));

        // Full with concurrent pop
        cyc(1, 0, '0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, tup(k + 10, k), 0, 0);
        chk("fp_full", 64'(bus.count), 64'(8));
        log_q.delete();
        cyc(0, 1, tup(-5, 7), 0, 1);
        chk("fp_count", 64'(bus.count), 64'(8));
        chk("fp_ovf", 64'(bus.overflow), 64'(0));
        cyc(0, 0, '0, 1, 1);
        drain_until_done(20);
        chk("fp_len", 64'(log_q.size()), 64'(9));
        if (log_q.size() == 9) begin
            chk("fp_first", log_q[0], tup(10, 0));
            chk("fp_tail", log_q[8], tup(-5, 7));
        end

        // Wrap-around
        cyc(1, 0, '0, 0, 0);
        log_q.delete();
        for (int i = 0; i < 4; i++) cyc(0, 1, tup(100 + i, -i), 0, 0);
        for (int i = 4; i < 20; i++) begin
            cyc(0, 1, tup(100 + i, -i), 0, (i % 5) != 0);
            if (i % 5 == 3) cyc(0, 0, '0, 0, 1);
        end
        cyc(0, 0, '0, 1, 1);
        drain_until_done(20);
        chk("wrap_len", 64'(log_q.size()), 64'(20));
        for (int i = 0; i < 20 && i < log_q.size(); i++)
            chk("wrap_order", log_q[i], tup(100 + i, -i));

        // Flush / priority
        cyc(1, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, tup(i, i), 0, 0);
        chk("fl_pre", 64'(bus.count), 64'(4));
        cyc(1, 1, tup(9, 9), 0, 0);
        chk("fl_count", 64'(bus.count), 64'(0));
        chk("fl_valid", 64'(bus.out_valid), 64'(0));
        log_q.delete();
        cyc(0, 0, '0, 1, 1);
        drain_until_done(5);
        chk("fl_none", 64'(log_q.size()), 64'(0));

        // Async reset mid-drain
        cyc(1, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, tup(i + 1, 1), 0, 0);
        cyc(0, 0, '0, 1, 0);
        cyc(0, 0, '0, 0, 1);
        chk("ar_pre", 64'(bus.count), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 64'(bus.count), 64'(0));
        chk("ar_valid", 64'(bus.out_valid), 64'(0));
        chk("ar_last", 64'(bus.out_last), 64'(0));
        chk("ar_data", bus.out_data, 64'(0));
        chk("ar_done", 64'(bus.done), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(0, 1, tup(5, 5), 1, 1);
        cyc(0, 0, '0, 0, 1);
        chk("ar_hold", 64'(bus.done), 64'(0));
        chk("ar_hold_cnt", 64'(bus.count), 64'(0));
        cyc(1, 0, '0, 0, 1);
        cyc(0, 1, tup(6, 6), 1, 1);
        chk("ar_new", bus.out_data, tup(6, 6));
        drain_until_done(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/yield_collector.md
# yield_collector

Downstream consumer for generator-derived modules. It captures each yielded output tuple, strobed by a valid pulse, into a small FIFO. It re-presents the tuples on a ready/valid stream and reports completion once the producer has signalled done and every captured tuple has been drained. It sits between a generated module's `_outN`/`_done` ports and the testbench or host-side sink, so the generator never stalls on a slow consumer.

## Interface
- `WIDTH`, default 32: bits per tuple element; elements are signed.
- `NOUT`, default 2: elements per tuple.
- `DEPTH`, default 8: FIFO entries; must be a power of two and at least 2.
- `_clock  in  1`: single clock; everything is on the rising edge.
- `_reset_n  in  1`: asynchronous, active-low reset.
- `_start  in  1`: synchronous flush and arm; pulse once per generator run.
- `_in_valid  in  1`: producer yielded a tuple this cycle.
- `_in_data  in  NOUT*WIDTH`: tuple; element k is `[k*WIDTH +: WIDTH]` (element 0 maps to `_out0`).
- `_in_done  in  1`: producer finished; level or pulse, latched internally.
- `_out_valid  out  1`: head tuple available.
- `_out_ready  in  1`: sink accepts the head tuple.
- `_out_data  out  NOUT*WIDTH`: head tuple, same packing as `_in_data`.
- `_out_last  out  1`: head is the final tuple of the run.
- `_count  out  $clog2(DEPTH+1)`: current occupancy.
- `_overflow  out  1`: sticky flag; a tuple was dropped because the FIFO was full.
- `_done  out  1`: run complete and FIFO empty.

## Operation
- **States** (`yc_state_t`): IDLE, COLLECT, DRAIN, DONE. Reset enters IDLE.
- **IDLE:** inputs ignored. `_start` moves to COLLECT.
- **COLLECT:** a tuple is written when `_in_valid` is high and the FIFO is not full.
  - If `_in_valid` is high while full and no pop occurs that cycle, the tuple is dropped and `_overflow` is set.
  - `_in_done` moves to DRAIN. A tuple presented in the same cycle as `_in_done` is still captured.
- **DRAIN:** `_in_valid` is ignored. When the FIFO becomes empty, the state moves to DONE.
- **DONE:** `_done` is 1. It holds until `_start` or reset.
- **Pop:** occurs when `_out_valid` and `_out_ready` are both high. `_out_data` is first-word-fall-through, driven from `mem[rd_ptr]`.
- **Full with concurrent pop:** a push and a pop in the same cycle are both accepted. `_count` is unchanged and there is no overflow.
- **`_out_last`:** equals `_out_valid` AND (`_count`==1) AND state is DRAIN.
- **`_start` in any state:**
  - Pointers, `_count`, `_overflow`, `_done` and the latched done flag all clear.
  - State goes to COLLECT.
  - `_start` has priority over `_in_valid` and `_in_done` in the same cycle; those inputs are discarded.
- **Pointers:** `$clog2(DEPTH)`-bit and wrap naturally. Full and empty are derived from `_count`, never from pointer equality.
- **Reset values:** all outputs 0, state IDLE, pointers 0. Memory contents are not reset.

## Timing
- Write at edge N: `_out_valid` is 1 after edge N, so capture-to-visible latency is 1 cycle.
- Pop at edge N: the next head, or `_out_valid`=0, is presented after edge N.
- Last pop at edge N in DRAIN: `_done`=1 after edge N+1, i.e. one cycle for the state update.
- `_in_done` while the FIFO is already empty in COLLECT: DRAIN after edge N, DONE after edge N+1.
- `_reset_n` deasserted mid-run: all outputs go to their reset values asynchronously. Operation resumes only after a new `_start`.
- `_overflow` asserts after the edge on which the drop occurs.

## Structure
- **Package `yield_pkg`:**
  - `yc_state_t` enum.
  - Default `WIDTH`, `NOUT`, `DEPTH` localparams.
  - `count_w(depth)` function.
- **Sub-module `yield_fifo_mem`:**
  - Parameterised `DEPTH` x `NOUT*WIDTH` storage.
  - Synchronous write, asynchronous read.
  - Holds pointer and count logic and exposes `full`/`empty`.
- **Top level:** the FSM, the done latch and the overflow flag.

## Test plan
- **Basic run:** `_start`; push (1,2), then (3,4); `_in_done` with the second push; hold `_out_ready`=1.
  - Expect (1,2) then (3,4) on consecutive cycles.
  - `_out_last`=1 on (3,4) only.
  - `_done`=1 one cycle after the second pop.
- **Backpressure / overflow:** `_out_ready`=0, DEPTH=8; push 9 tuples (k,-k), k=0..8.
  - Expect `_count`=8 and `_overflow`=1 after the 9th push.
  - After releasing ready, the drain yields k=0..7 in order and (8,-8) is absent.
- **Full with concurrent pop:** FIFO full and `_out_ready`=1; push (-5,7).
  - Expect `_count` to stay 8, `_overflow`=0, and (-5,7) to be the last element out.
- **Wrap-around:** 20 pushes interleaved with pops, occupancy kept between 3 and 6.
  - Expect output order identical to input order, including across pointer wrap.
- **Flush / priority:** with 4 entries queued, assert `_start` together with `_in_valid` carrying (9,9).
  - Expect `_count`=0, `_out_valid`=0, and (9,9) never output.
- **Async reset:** drop `_reset_n` mid-DRAIN.
  - Expect all outputs 0 immediately and `_done` to stay 0 until a new run completes.
